// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Package  : y86_pkg
// Purpose  : Shared types and constants for the Y86-64 pipeline: status
//            codes, instruction codes, register-file sentinels and the
//            W pipeline register layout.
// Revision : 1.0 - initial release
// ============================================================================
package y86_pkg;

  // Instruction status codes
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  // Instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Register index meaning "no register"
  localparam logic [3:0] RNONE = 4'hF;

  // Number of architectural registers (RNONE is not backed by storage)
  localparam int NREGS = 15;

  typedef struct packed {
    logic        valid;
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } w_reg_t;

  // A bubble is an invalid NOP that reports AOK and writes nothing.
  function automatic w_reg_t w_bubble();
    w_reg_t w;
    w.valid = 1'b0;
    w.stat  = SAOK;
    w.icode = INOP;
    w.valE  = 64'd0;
    w.valM  = 64'd0;
    w.dstE  = RNONE;
    w.dstM  = RNONE;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/y86_writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module   : y86_writeback_regfile
// Purpose  : 15 x 64-bit Y86-64 register file. Two combinational read ports,
//            one debug read port and two write ports sharing one enable.
//            Port M is applied after port E, so M wins on a common index.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            i_we             - commit enable for both write ports
//            i_dstE/i_valE    - write port E (index F = no write)
//            i_dstM/i_valM    - write port M (index F = no write)
//            i_srcA/i_srcB    - read indices (F reads as 0)
//            o_rA/o_rB        - read data, array contents only
//            i_dbg_sel/o_dbg  - debug read (F reads as 0)
// Revision : 1.0 - initial release
// ============================================================================
module y86_writeback_regfile
  import y86_pkg::*;
#(
  parameter logic [63:0] STACK_INIT = 64'd256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [3:0]  i_dstE,
  input  logic [63:0] i_valE,
  input  logic [3:0]  i_dstM,
  input  logic [63:0] i_valM,
  input  logic [3:0]  i_srcA,
  input  logic [3:0]  i_srcB,
  output logic [63:0] o_rA,
  output logic [63:0] o_rB,
  input  logic [3:0]  i_dbg_sel,
  output logic [63:0] o_dbg
);

  logic [63:0] r_regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= (i == 4) ? STACK_INIT : 64'd0;
      end
    end else if (i_we) begin
      if (i_dstE != RNONE) r_regs[i_dstE] <= i_valE;
      // Later assignment wins: popq %rsp keeps the popped value.
      if (i_dstM != RNONE) r_regs[i_dstM] <= i_valM;
    end
  end

  assign o_rA  = (i_srcA    == RNONE) ? 64'd0 : r_regs[i_srcA];
  assign o_rB  = (i_srcB    == RNONE) ? 64'd0 : r_regs[i_srcB];
  assign o_dbg = (i_dbg_sel == RNONE) ? 64'd0 : r_regs[i_dbg_sel];

endmodule
`default_nettype wire

// File: rtl/y86_writeback.sv
`default_nettype none
// ============================================================================
// Module   : y86_writeback
// Purpose  : Write-back stage of the pipelined Y86-64 core. Holds the W
//            pipeline register, commits valE/valM into the register file,
//            serves the decode read ports (optionally bypassing the pending
//            W write), tracks the sticky halt state and counts retirements.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            W_stall, W_bubble        - W register hold / bubble controls
//            m_stat..m_dstM           - memory-stage results to latch
//            srcA/srcB, rvalA/rvalB   - decode read ports (combinational)
//            W_dstE/W_dstM/W_valE/W_valM - W contents for decode forwarding
//            stat, halted, retired    - status, sticky halt, retire count
//            dbg_sel, dbg_val         - debug register read
// Revision : 1.0 - initial release
// ============================================================================
module y86_writeback
  import y86_pkg::*;
#(
  parameter logic [63:0] STACK_INIT = 64'd256,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        W_stall,
  input  logic        W_bubble,
  input  logic [2:0]  m_stat,
  input  logic [3:0]  m_icode,
  input  logic [63:0] m_valE,
  input  logic [63:0] m_valM,
  input  logic [3:0]  m_dstE,
  input  logic [3:0]  m_dstM,
  input  logic [3:0]  srcA,
  input  logic [3:0]  srcB,
  output logic [63:0] rvalA,
  output logic [63:0] rvalB,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [2:0]  stat,
  output logic        halted,
  output logic [63:0] retired,
  input  logic [3:0]  dbg_sel,
  output logic [63:0] dbg_val
);

  w_reg_t      r_w;
  logic        r_halted;
  logic [63:0] r_retired;

  logic        w_we;
  logic        w_exc;
  logic [63:0] w_arr_rA;
  logic [63:0] w_arr_rB;
  logic        w_unused_icode;

  // A stalled W is re-presented next cycle, so committing now would
  // write (and count) it twice.
  assign w_we  = r_w.valid && (r_w.stat == SAOK) && !r_halted && !W_stall;
  assign w_exc = r_w.valid && (r_w.stat != SAOK);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_w       <= w_bubble();
      r_halted  <= 1'b0;
      r_retired <= 64'd0;
    end else if (!r_halted) begin
      if (w_exc) r_halted <= 1'b1;
      if (w_we)  r_retired <= r_retired + 64'd1;
      if (!W_stall) begin
        if (W_bubble) begin
          r_w <= w_bubble();
        end else begin
          r_w.valid <= 1'b1;
          r_w.stat  <= m_stat;
          r_w.icode <= m_icode;
          r_w.valE  <= m_valE;
          r_w.valM  <= m_valM;
          r_w.dstE  <= m_dstE;
          r_w.dstM  <= m_dstM;
        end
      end
    end
  end

  y86_writeback_regfile #(
    .STACK_INIT (STACK_INIT)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_we),
    .i_dstE    (r_w.dstE),
    .i_valE    (r_w.valE),
    .i_dstM    (r_w.dstM),
    .i_valM    (r_w.valM),
    .i_srcA    (srcA),
    .i_srcB    (srcB),
    .o_rA      (w_arr_rA),
    .o_rB      (w_arr_rB),
    .i_dbg_sel (dbg_sel),
    .o_dbg     (dbg_val)
  );

  generate
    if (BYPASS) begin : g_bypass
      // M is checked before E to mirror the write-port ordering.
      assign rvalA = (srcA == RNONE)                ? 64'd0    :
                     (w_we && (srcA == r_w.dstM))   ? r_w.valM :
                     (w_we && (srcA == r_w.dstE))   ? r_w.valE :
                                                      w_arr_rA;
      assign rvalB = (srcB == RNONE)                ? 64'd0    :
                     (w_we && (srcB == r_w.dstM))   ? r_w.valM :
                     (w_we && (srcB == r_w.dstE))   ? r_w.valE :
                                                      w_arr_rB;
    end else begin : g_no_bypass
      assign rvalA = w_arr_rA;
      assign rvalB = w_arr_rB;
    end
  endgenerate

  assign W_dstE  = r_w.dstE;
  assign W_dstM  = r_w.dstM;
  assign W_valE  = r_w.valE;
  assign W_valM  = r_w.valM;
  assign stat    = r_w.stat;
  assign halted  = r_halted;
  assign retired = r_retired;

  // icode travels with the instruction but no write-back decision uses it.
  assign w_unused_icode = ^r_w.icode;

endmodule
`default_nettype wire

// File: tb/tb_y86_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_y86_writeback
// Purpose  : Self-checking bench for y86_writeback. Two instances (bypass on
//            and off) share all inputs. Directed table rows and hand-written
//            sequences check fixed expectations; a random phase compares
//            against an architectural model of the register file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_y86_writeback;
  import y86_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, W_stall, W_bubble;
  logic [2:0]  m_stat;
  logic [3:0]  m_icode, m_dstE, m_dstM, srcA, srcB, dbg_sel;
  logic [63:0] m_valE, m_valM;

  logic [63:0] rvalA_1, rvalB_1, W_valE_1, W_valM_1, retired_1, dbg_val_1;
  logic [3:0]  W_dstE_1, W_dstM_1;
  logic [2:0]  stat_1;
  logic        halted_1;
  logic [63:0] rvalA_0, rvalB_0, W_valE_0, W_valM_0, retired_0, dbg_val_0;
  logic [3:0]  W_dstE_0, W_dstM_0;
  logic [2:0]  stat_0;
  logic        halted_0;

  y86_writeback #(.STACK_INIT(64'd256), .BYPASS(1'b1)) dut1 (
    .clk(clk), .rst(rst), .W_stall(W_stall), .W_bubble(W_bubble),
    .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE), .m_valM(m_valM),
    .m_dstE(m_dstE), .m_dstM(m_dstM), .srcA(srcA), .srcB(srcB),
    .rvalA(rvalA_1), .rvalB(rvalB_1), .W_dstE(W_dstE_1), .W_dstM(W_dstM_1),
    .W_valE(W_valE_1), .W_valM(W_valM_1), .stat(stat_1), .halted(halted_1),
    .retired(retired_1), .dbg_sel(dbg_sel), .dbg_val(dbg_val_1));

  y86_writeback #(.STACK_INIT(64'd256), .BYPASS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .W_stall(W_stall), .W_bubble(W_bubble),
    .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE), .m_valM(m_valM),
    .m_dstE(m_dstE), .m_dstM(m_dstM), .srcA(srcA), .srcB(srcB),
    .rvalA(rvalA_0), .rvalB(rvalB_0), .W_dstE(W_dstE_0), .W_dstM(W_dstM_0),
    .W_valE(W_valE_0), .W_valM(W_valM_0), .stat(stat_0), .halted(halted_0),
    .retired(retired_0), .dbg_sel(dbg_sel), .dbg_val(dbg_val_0));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- architectural model ----------------
  logic [63:0]     mr [15];
  bit              mvalid, mhalt;
  logic [2:0]      mstat;
  logic [3:0]      mdE, mdM;
  logic [63:0]     mvE, mvM;
  longint unsigned mret;

  function automatic bit m_commit();
    return mvalid && (mstat == 3'd1) && !mhalt && !W_stall;
  endfunction

  function automatic logic [63:0] m_read(input logic [3:0] s, input bit bp);
    if (s == 4'hF) return 64'd0;
    if (bp && m_commit() && s == mdM) return mvM;
    if (bp && m_commit() && s == mdE) return mvE;
    return mr[s];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 15; i++) mr[i] = (i == 4) ? 64'd256 : 64'd0;
    mvalid = 0; mstat = 3'd1; mdE = 4'hF; mdM = 4'hF; mvE = 0; mvM = 0;
    mhalt = 0; mret = 0;
  endtask

  task automatic m_edge();
    bit c;
    if (rst) begin
      m_reset();
    end else if (!mhalt) begin
      c = m_commit();
      if (c) begin
        if (mdE != 4'hF) mr[mdE] = mvE;
        if (mdM != 4'hF) mr[mdM] = mvM;
        mret++;
      end
      if (mvalid && mstat != 3'd1) mhalt = 1;
      if (!W_stall) begin
        if (W_bubble) begin
          mvalid = 0; mstat = 3'd1; mdE = 4'hF; mdM = 4'hF; mvE = 0; mvM = 0;
        end else begin
          mvalid = 1; mstat = m_stat; mdE = m_dstE; mdM = m_dstM;
          mvE = m_valE; mvM = m_valM;
        end
      end
    end
  endtask

  task automatic step();
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [63:0] exp_dbg;
    exp_dbg = (dbg_sel == 4'hF) ? 64'd0 : mr[dbg_sel];
    chk({tag, ".rvalA_bp"},  rvalA_1, m_read(srcA, 1));
    chk({tag, ".rvalB_bp"},  rvalB_1, m_read(srcB, 1));
    chk({tag, ".rvalA_nbp"}, rvalA_0, m_read(srcA, 0));
    chk({tag, ".rvalB_nbp"}, rvalB_0, m_read(srcB, 0));
    chk({tag, ".dbg"},       dbg_val_1, exp_dbg);
    chk({tag, ".dbg_nbp"},   dbg_val_0, exp_dbg);
    chk({tag, ".stat"},      {61'd0, stat_1}, {61'd0, mstat});
    chk({tag, ".halted"},    {63'd0, halted_1}, {63'd0, mhalt});
    chk({tag, ".retired"},   retired_1, mret);
    chk({tag, ".retired_nbp"}, retired_0, mret);
    chk({tag, ".W_dstE"},    {60'd0, W_dstE_1}, {60'd0, mdE});
    chk({tag, ".W_dstM"},    {60'd0, W_dstM_1}, {60'd0, mdM});
    chk({tag, ".W_valE"},    W_valE_1, mvE);
    chk({tag, ".W_valM"},    W_valM_1, mvM);
  endtask

  task automatic set_in(input logic st, input logic bb, input logic [2:0] s,
                        input logic [3:0] ic, input logic [3:0] de, input logic [63:0] ve,
                        input logic [3:0] dm, input logic [63:0] vm);
    W_stall = st; W_bubble = bb; m_stat = s; m_icode = ic;
    m_dstE = de; m_valE = ve; m_dstM = dm; m_valM = vm;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        st, bb;
    logic [2:0]  s;
    logic [3:0]  ic, de, dm, sa, sb, dsel;
    logic [63:0] ve, vm;
    logic [63:0] e_dbg, e_ret, e_ra1, e_ra0, e_rb;
  } vec_t;

  vec_t tbl [11];

  function automatic vec_t mk(input logic st, input logic bb, input logic [3:0] ic,
                              input logic [3:0] de, input logic [63:0] ve,
                              input logic [3:0] dm, input logic [63:0] vm,
                              input logic [3:0] sa, input logic [3:0] sb,
                              input logic [3:0] dsel, input logic [63:0] e_dbg,
                              input logic [63:0] e_ret, input logic [63:0] e_ra1,
                              input logic [63:0] e_ra0, input logic [63:0] e_rb);
    vec_t v;
    v.st = st; v.bb = bb; v.s = 3'd1; v.ic = ic; v.de = de; v.ve = ve;
    v.dm = dm; v.vm = vm; v.sa = sa; v.sb = sb; v.dsel = dsel;
    v.e_dbg = e_dbg; v.e_ret = e_ret; v.e_ra1 = e_ra1; v.e_ra0 = e_ra0; v.e_rb = e_rb;
    return v;
  endfunction

  initial begin
    //            st bb  ic    dE    valE  dM    valM sA    sB    dbg  e_dbg ret rA1  rA0  rB
    tbl[0]  = mk(0, 0, 4'h3, 4'h2, 101,  4'hF, 0,   4'hF, 4'hF, 4'h2, 0,   0,  0,   0,   0);
    tbl[1]  = mk(0, 0, 4'h1, 4'hF, 0,    4'hF, 0,   4'h2, 4'hF, 4'h2, 101, 1,  101, 101, 0);
    tbl[2]  = mk(0, 0, 4'hB, 4'h4, 264,  4'h4, 77,  4'h4, 4'h2, 4'h4, 256, 2,  77,  256, 101);
    tbl[3]  = mk(0, 1, 4'h3, 4'h5, 999,  4'hF, 0,   4'h5, 4'hF, 4'h4, 77,  3,  0,   0,   0);
    tbl[4]  = mk(0, 0, 4'h3, 4'h3, 5,    4'hF, 0,   4'h3, 4'h4, 4'h5, 0,   3,  5,   0,   77);
    tbl[5]  = mk(1, 0, 4'h3, 4'h6, 8,    4'hF, 0,   4'h3, 4'hF, 4'h3, 0,   3,  0,   0,   0);
    tbl[6]  = mk(1, 1, 4'h3, 4'h6, 8,    4'hF, 0,   4'h3, 4'hF, 4'h3, 0,   3,  0,   0,   0);
    tbl[7]  = mk(1, 0, 4'h3, 4'h6, 8,    4'hF, 0,   4'h3, 4'hF, 4'h3, 0,   3,  0,   0,   0);
    tbl[8]  = mk(0, 1, 4'h3, 4'h6, 8,    4'hF, 0,   4'h3, 4'hF, 4'h3, 5,   4,  5,   5,   0);
    tbl[9]  = mk(0, 0, 4'h3, 4'h6, 8,    4'hF, 0,   4'h6, 4'hF, 4'h6, 0,   4,  8,   0,   0);
    tbl[10] = mk(0, 1, 4'h1, 4'hF, 0,    4'hF, 0,   4'h6, 4'hF, 4'h6, 8,   5,  8,   8,   0);

    rst = 1'b1;
    set_in(0, 0, 3'd1, 4'h1, 4'hF, 0, 4'hF, 0);
    srcA = 4'hF; srcB = 4'hF; dbg_sel = 4'h4;
    m_reset();
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("reset.R4", dbg_val_1, 64'd256);
    dbg_sel = 4'h0; #1;
    chk("reset.R0", dbg_val_1, 64'd0);
    dbg_sel = 4'hF; #1;
    chk("reset.dbgF", dbg_val_1, 64'd0);
    chk("reset.retired", retired_1, 64'd0);
    chk("reset.stat", {61'd0, stat_1}, 64'd1);
    chk("reset.halted", {63'd0, halted_1}, 64'd0);
    chk("reset.W_dstE", {60'd0, W_dstE_1}, 64'hF);

    // Directed table
    for (int i = 0; i < 11; i++) begin
      set_in(tbl[i].st, tbl[i].bb, tbl[i].s, tbl[i].ic, tbl[i].de, tbl[i].ve,
             tbl[i].dm, tbl[i].vm);
      srcA = tbl[i].sa; srcB = tbl[i].sb; dbg_sel = tbl[i].dsel;
      step();
      chk($sformatf("tbl%0d.dbg", i),       dbg_val_1, tbl[i].e_dbg);
      chk($sformatf("tbl%0d.retired", i),   retired_1, tbl[i].e_ret);
      chk($sformatf("tbl%0d.rvalA_bp", i),  rvalA_1,   tbl[i].e_ra1);
      chk($sformatf("tbl%0d.rvalA_nbp", i), rvalA_0,   tbl[i].e_ra0);
      chk($sformatf("tbl%0d.rvalB_bp", i),  rvalB_1,   tbl[i].e_rb);
      check_model($sformatf("tbl%0d", i));
    end

    // Exception: ADR load halts without writing R0
    set_in(0, 0, 3'd3, 4'h5, 4'hF, 0, 4'h0, 9);
    srcA = 4'h0; srcB = 4'hF; dbg_sel = 4'h0;
    step();
    chk("exc.halted_pre", {63'd0, halted_1}, 64'd0);
    chk("exc.stat_pre", {61'd0, stat_1}, 64'd3);
    step();
    chk("exc.halted", {63'd0, halted_1}, 64'd1);
    chk("exc.stat", {61'd0, stat_1}, 64'd3);
    chk("exc.R0", dbg_val_1, 64'd0);
    chk("exc.retired", retired_1, 64'd5);
    set_in(0, 0, 3'd1, 4'h3, 4'h0, 7, 4'hF, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("halt%0d.R0", k), dbg_val_1, 64'd0);
      chk($sformatf("halt%0d.rvalA", k), rvalA_1, 64'd0);
      chk($sformatf("halt%0d.retired", k), retired_1, 64'd5);
      chk($sformatf("halt%0d.halted", k), {63'd0, halted_1}, 64'd1);
      chk($sformatf("halt%0d.stat", k), {61'd0, stat_1}, 64'd3);
      check_model($sformatf("halt%0d", k));
    end
    rst = 1'b1; step(); rst = 1'b0;
    dbg_sel = 4'h2; #1;
    chk("rst.halted", {63'd0, halted_1}, 64'd0);
    chk("rst.stat", {61'd0, stat_1}, 64'd1);
    chk("rst.retired", retired_1, 64'd0);
    chk("rst.R2", dbg_val_1, 64'd0);

    // Reset while a write is pending discards it
    set_in(0, 0, 3'd1, 4'h3, 4'h7, 55, 4'hF, 0);
    dbg_sel = 4'h7;
    step();
    rst = 1'b1; step(); rst = 1'b0; #1;
    chk("rstmid.R7", dbg_val_1, 64'd0);
    chk("rstmid.retired", retired_1, 64'd0);
    check_model("rstmid");

    // Random phase against the model
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 59) == 0);
      W_stall  = ($urandom_range(0, 4) == 0);
      W_bubble = ($urandom_range(0, 4) == 0);
      m_stat   = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      m_icode  = 4'($urandom_range(0, 11));
      m_dstE   = 4'($urandom_range(0, 15));
      m_dstM   = ($urandom_range(0, 2) == 0) ? m_dstE : 4'($urandom_range(0, 15));
      m_valE   = {$urandom, $urandom};
      m_valM   = {$urandom, $urandom};
      srcA     = 4'($urandom_range(0, 15));
      srcB     = 4'($urandom_range(0, 15));
      dbg_sel  = 4'($urandom_range(0, 15));
      step();
      check_model($sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
